// File: rtl/memory_responder.sv
// Data-memory responder: 124-byte RAM plus four display registers at 0x7C-0x7F,
// completes each request after WAIT_STATES wait cycles. Define MEM_PROTECT_EN to drop writes below PROTECT_TOP.
module memory_responder #(
  parameter int                ADDR_W      = 7,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = 7'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memory_en,
  input  logic              memory_read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              busy,
  output logic              error,
  output logic [31:0]       disp_out
);

  localparam int                RAM_DEPTH = 124;
  localparam logic [ADDR_W-1:0] DISP_BASE = 7'h7C;
  localparam logic [3:0]        WS_L      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   read_data_q;
  logic                ready_q, busy_q, error_q;
  logic [31:0]         disp_q;
  logic [DATA_W-1:0]   mem [0:RAM_DEPTH-1];

  logic                req_rd_s;
  logic [ADDR_W-1:0]   req_addr_s;
  logic [DATA_W-1:0]   req_wdata_s;
  logic                commit_s;
  logic                is_disp_s;
  logic                wr_blocked_s;
  logic                ram_we_s;
  logic [DATA_W-1:0]   rd_val_s;

  // Next-state and request-latch logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (memory_en) begin
          op_d    = memory_read;
          addr_d  = address;
          wdata_d = write_data;
          cnt_d   = WS_L;
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so use the live request then
  always_comb begin
    req_rd_s    = (state_q == S_IDLE) ? memory_read : op_q;
    req_addr_s  = (state_q == S_IDLE) ? address     : addr_q;
    req_wdata_s = (state_q == S_IDLE) ? write_data  : wdata_q;
    commit_s    = (state_d == S_RESP);
    is_disp_s   = (req_addr_s >= DISP_BASE);
`ifdef MEM_PROTECT_EN
    wr_blocked_s = !req_rd_s && !is_disp_s && (req_addr_s < PROTECT_TOP);
`else
    wr_blocked_s = 1'b0;
`endif
    ram_we_s = rst_n && commit_s && !req_rd_s && !is_disp_s && !wr_blocked_s;
    if (is_disp_s) begin
      rd_val_s = disp_q[{req_addr_s[1:0], 3'b000} +: 8];
    end else begin
      rd_val_s = mem[req_addr_s];
    end
  end

`ifndef MEM_PROTECT_EN
  logic unused_protect_s;
  assign unused_protect_s = ^PROTECT_TOP;
`endif

  // RAM array; intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem[req_addr_s] <= req_wdata_s;
    end
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 1'b0;
      addr_q      <= 7'h00;
      wdata_q     <= 8'h00;
      read_data_q <= 8'h00;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      disp_q      <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == S_RESP);
      busy_q  <= (state_d != S_IDLE);
      error_q <= commit_s && wr_blocked_s;
      if (commit_s && req_rd_s) begin
        read_data_q <= rd_val_s;
      end
      if (commit_s && !req_rd_s && is_disp_s) begin
        disp_q[{req_addr_s[1:0], 3'b000} +: 8] <= req_wdata_s;
      end
    end
  end

  assign read_data = read_data_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign error     = error_q;
  assign disp_out  = disp_q;

endmodule
